// File: rtl/axil_master_if.sv
// Command/response port plus the five AXI4-Lite channels of axil_master.
// The master modport is the axil_master view; slave is the view of the logic around it.
interface axil_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_wstrb;
  logic [2:0]        cmd_prot;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_resp;
  logic              rsp_timeout;

  logic [ADDR_W-1:0] axi_awaddr;
  logic [2:0]        axi_awprot;
  logic              axi_awvalid;
  logic              axi_awready;
  logic [DATA_W-1:0] axi_wdata;
  logic [STRB_W-1:0] axi_wstrb;
  logic              axi_wvalid;
  logic              axi_wready;
  logic [1:0]        axi_bresp;
  logic              axi_bvalid;
  logic              axi_bready;
  logic [ADDR_W-1:0] axi_araddr;
  logic [2:0]        axi_arprot;
  logic              axi_arvalid;
  logic              axi_arready;
  logic [DATA_W-1:0] axi_rdata;
  logic [1:0]        axi_rresp;
  logic              axi_rvalid;
  logic              axi_rready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, cmd_prot,
    output cmd_ready,
    output rsp_valid, rsp_write, rsp_rdata, rsp_resp, rsp_timeout,
    input  rsp_ready,
    output axi_awaddr, axi_awprot, axi_awvalid,
    input  axi_awready,
    output axi_wdata, axi_wstrb, axi_wvalid,
    input  axi_wready,
    input  axi_bresp, axi_bvalid,
    output axi_bready,
    output axi_araddr, axi_arprot, axi_arvalid,
    input  axi_arready,
    input  axi_rdata, axi_rresp, axi_rvalid,
    output axi_rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, cmd_prot,
    input  cmd_ready,
    input  rsp_valid, rsp_write, rsp_rdata, rsp_resp, rsp_timeout,
    output rsp_ready,
    input  axi_awaddr, axi_awprot, axi_awvalid,
    output axi_awready,
    input  axi_wdata, axi_wstrb, axi_wvalid,
    output axi_wready,
    output axi_bresp, axi_bvalid,
    input  axi_bready,
    input  axi_araddr, axi_arprot, axi_arvalid,
    output axi_arready,
    output axi_rdata, axi_rresp, axi_rvalid,
    input  axi_rready
  );
endinterface

// File: rtl/axil_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI-Lite access out,
// exactly one response back (slave answer or response-phase timeout).
module axil_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input logic           aclk,
  input logic           aresetn,
  axil_master_if.master bus
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN  = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    RESP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] to_cnt;
  logic             to_hit;

  // Fires on the edge that closes the TIMEOUT-th cycle spent in a response state.
  assign to_hit = TO_EN && (to_cnt == TO_LAST);

  // NOTE: every register here uses non-blocking assignment, so all branches see
  // the pre-edge values of awvalid/wvalid and the handshakes resolve consistently.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state            <= IDLE;
      to_cnt           <= '0;
      bus.cmd_ready    <= 1'b0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_write    <= 1'b0;
      bus.rsp_rdata    <= {DATA_W{1'b0}};
      bus.rsp_resp     <= 2'b00;
      bus.rsp_timeout  <= 1'b0;
      bus.axi_awaddr   <= {ADDR_W{1'b0}};
      bus.axi_awprot   <= 3'b000;
      bus.axi_awvalid  <= 1'b0;
      bus.axi_wdata    <= {DATA_W{1'b0}};
      bus.axi_wstrb    <= {STRB_W{1'b0}};
      bus.axi_wvalid   <= 1'b0;
      bus.axi_bready   <= 1'b0;
      bus.axi_araddr   <= {ADDR_W{1'b0}};
      bus.axi_arprot   <= 3'b000;
      bus.axi_arvalid  <= 1'b0;
      bus.axi_rready   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.cmd_ready <= 1'b1;
          if (bus.cmd_valid && bus.cmd_ready) begin
            bus.cmd_ready   <= 1'b0;
            bus.rsp_write   <= bus.cmd_write;
            bus.rsp_rdata   <= {DATA_W{1'b0}};
            bus.rsp_resp    <= 2'b00;
            bus.rsp_timeout <= 1'b0;
            if (bus.cmd_write) begin
              bus.axi_awaddr  <= bus.cmd_addr;
              bus.axi_awprot  <= bus.cmd_prot;
              bus.axi_wdata   <= bus.cmd_wdata;
              bus.axi_wstrb   <= bus.cmd_wstrb;
              bus.axi_awvalid <= 1'b1;
              bus.axi_wvalid  <= 1'b1;
              state           <= WR_REQ;
            end else begin
              bus.axi_araddr  <= bus.cmd_addr;
              bus.axi_arprot  <= bus.cmd_prot;
              bus.axi_arvalid <= 1'b1;
              state           <= RD_REQ;
            end
          end
        end

        WR_REQ: begin
          // AW and W retire independently; move on once neither is still pending.
          if (bus.axi_awready) bus.axi_awvalid <= 1'b0;
          if (bus.axi_wready)  bus.axi_wvalid  <= 1'b0;
          if ((!bus.axi_awvalid || bus.axi_awready) &&
              (!bus.axi_wvalid  || bus.axi_wready)) begin
            bus.axi_bready <= 1'b1;
            to_cnt         <= '0;
            state          <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (bus.axi_bvalid) begin
            bus.rsp_resp   <= bus.axi_bresp;
            bus.axi_bready <= 1'b0;
            bus.rsp_valid  <= 1'b1;
            state          <= RESP;
          end else if (to_hit) begin
            bus.rsp_resp    <= RESP_SLVERR;
            bus.rsp_timeout <= 1'b1;
            bus.rsp_rdata   <= {DATA_W{1'b0}};
            bus.axi_bready  <= 1'b0;
            bus.rsp_valid   <= 1'b1;
            state           <= RESP;
          end else if (to_cnt != '1) begin
            to_cnt <= to_cnt + CNT_W'(1);
          end
        end

        RD_REQ: begin
          if (bus.axi_arready) begin
            bus.axi_arvalid <= 1'b0;
            bus.axi_rready  <= 1'b1;
            to_cnt          <= '0;
            state           <= RD_RESP;
          end
        end

        RD_RESP: begin
          if (bus.axi_rvalid) begin
            bus.rsp_rdata  <= bus.axi_rdata;
            bus.rsp_resp   <= bus.axi_rresp;
            bus.axi_rready <= 1'b0;
            bus.rsp_valid  <= 1'b1;
            state          <= RESP;
          end else if (to_hit) begin
            bus.rsp_resp    <= RESP_SLVERR;
            bus.rsp_timeout <= 1'b1;
            bus.rsp_rdata   <= {DATA_W{1'b0}};
            bus.axi_rready  <= 1'b0;
            bus.rsp_valid   <= 1'b1;
            state           <= RESP;
          end else if (to_cnt != '1) begin
            to_cnt <= to_cnt + CNT_W'(1);
          end
        end

        RESP: begin
          // cmd_ready is raised on the handshake edge so the next command can go
          // in one cycle later.
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_master.sv
// Directed bench for axil_master: expected responses are queued as commands are
// issued and compared when the response handshake happens.
module tb_axil_master;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;

  always #5 aclk = ~aclk;

  axil_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axil_master #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .bus    (bus.master)
  );

  typedef struct {
    logic        write;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        timeout;
  } rsp_t;

  rsp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   b_hs  = 0;

  always @(posedge aclk) begin
    if (aresetn && bus.axi_bvalid && bus.axi_bready) b_hs++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic expect_rsp(input logic wr, input logic [31:0] rdata,
                            input logic [1:0] resp, input logic to);
    rsp_t e;
    e.write   = wr;
    e.rdata   = rdata;
    e.resp    = resp;
    e.timeout = to;
    exp_q.push_back(e);
  endtask

  // Returns just after the edge that accepted the command.
  task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [2:0] prot);
    bit ok = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = data;
    bus.cmd_wstrb = strb;
    bus.cmd_prot  = prot;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = bus.cmd_ready;
      tick();
    end
    bus.cmd_valid = 1'b0;
    check("cmd_accept", ok, 1);
  endtask

  task automatic take_rsp(input string tag);
    rsp_t e;
    bit   got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (bus.rsp_valid) begin
        got = 1'b1;
        check({tag, "_sb_nonempty"}, exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check({tag, "_rdata"}, bus.rsp_rdata, e.rdata);
          check({tag, "_wr_to_resp"}, {bus.rsp_write, bus.rsp_timeout, bus.rsp_resp},
                {e.write, e.timeout, e.resp});
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
      end else begin
        tick();
      end
    end
    check({tag, "_rsp_seen"}, got, 1);
  endtask

  initial begin
    int b0;
    int n;

    bus.cmd_valid   = 1'b0;
    bus.cmd_write   = 1'b0;
    bus.cmd_addr    = '0;
    bus.cmd_wdata   = '0;
    bus.cmd_wstrb   = '0;
    bus.cmd_prot    = '0;
    bus.rsp_ready   = 1'b0;
    bus.axi_awready = 1'b0;
    bus.axi_wready  = 1'b0;
    bus.axi_bresp   = 2'b00;
    bus.axi_bvalid  = 1'b0;
    bus.axi_arready = 1'b0;
    bus.axi_rdata   = '0;
    bus.axi_rresp   = 2'b00;
    bus.axi_rvalid  = 1'b0;

    // Reset state
    #12;
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_valids", {bus.axi_awvalid, bus.axi_wvalid, bus.axi_arvalid,
                         bus.axi_bready, bus.axi_rready, bus.rsp_valid}, 0);
    check("rst_data", {bus.axi_awaddr, bus.axi_wdata}, 0);
    check("rst_rsp", {bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout, bus.rsp_write}, 0);
    @(posedge aclk);
    #1 aresetn = 1'b1;
    check("rel_cmd_ready_low", bus.cmd_ready, 0);
    tick();
    check("rel_cmd_ready_high", bus.cmd_ready, 1);

    // Best-case write
    bus.axi_awready = 1'b1;
    bus.axi_wready  = 1'b1;
    bus.axi_bvalid  = 1'b1;
    bus.axi_bresp   = 2'b00;
    expect_rsp(1'b1, 32'h0, 2'b00, 1'b0);
    send_cmd(1'b1, 32'h10, 32'hA5A5_1234, 4'hF, 3'b010);
    check("wr1_valids_t1", {bus.axi_awvalid, bus.axi_wvalid, bus.cmd_ready}, 3'b110);
    check("wr1_awaddr", bus.axi_awaddr, 32'h10);
    check("wr1_wdata_strb_prot", {bus.axi_wdata, bus.axi_wstrb, bus.axi_awprot},
          {32'hA5A5_1234, 4'hF, 3'b010});
    tick();
    check("wr1_t2", {bus.axi_awvalid, bus.axi_wvalid, bus.axi_bready, bus.rsp_valid}, 4'b0010);
    tick();
    check("wr1_t3", {bus.axi_bready, bus.rsp_valid}, 2'b01);
    take_rsp("wr1");
    check("wr1_cmd_ready_after", {bus.cmd_ready, bus.rsp_valid}, 2'b10);

    // Write with awready delayed 3 cycles, SLVERR
    bus.axi_bvalid  = 1'b0;
    bus.axi_bresp   = 2'b10;
    bus.axi_awready = 1'b0;
    bus.axi_wready  = 1'b1;
    b0 = b_hs;
    expect_rsp(1'b1, 32'h0, 2'b10, 1'b0);
    send_cmd(1'b1, 32'h40, 32'h0BAD_F00D, 4'h3, 3'b000);
    check("wr2_valids_t1", {bus.axi_awvalid, bus.axi_wvalid}, 2'b11);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wr2_aw_hold", {bus.axi_awvalid, bus.axi_wvalid, bus.axi_bready, bus.axi_awaddr},
            {3'b100, 32'h40});
    end
    bus.axi_awready = 1'b1;
    tick();
    bus.axi_awready = 1'b0;
    check("wr2_aw_done", {bus.axi_awvalid, bus.axi_bready}, 2'b01);
    tick();
    tick();
    bus.axi_bvalid = 1'b1;
    tick();
    bus.axi_bvalid = 1'b0;
    check("wr2_b_done", {bus.axi_bready, bus.rsp_valid}, 2'b01);
    take_rsp("wr2");
    check("wr2_b_once", b_hs - b0, 1);

    // Read with slave answering after 5 cycles
    bus.axi_arready = 1'b1;
    expect_rsp(1'b0, 32'hDEAD_BEEF, 2'b00, 1'b0);
    send_cmd(1'b0, 32'h24, 32'h0, 4'h0, 3'b001);
    check("rd1_ar", {bus.axi_arvalid, bus.axi_awvalid, bus.axi_arprot, bus.axi_araddr},
          {2'b10, 3'b001, 32'h24});
    tick();
    check("rd1_ar_done", {bus.axi_arvalid, bus.axi_rready}, 2'b01);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rd1_rready_wait", {bus.axi_rready, bus.rsp_valid}, 2'b10);
    end
    bus.axi_rvalid = 1'b1;
    bus.axi_rdata  = 32'hDEAD_BEEF;
    bus.axi_rresp  = 2'b00;
    tick();
    bus.axi_rvalid = 1'b0;
    bus.axi_rdata  = '0;
    check("rd1_r_done", {bus.axi_rready, bus.rsp_valid}, 2'b01);
    take_rsp("rd1");

    // Read timeout: rvalid never comes
    expect_rsp(1'b0, 32'h0, 2'b10, 1'b1);
    send_cmd(1'b0, 32'h30, 32'h0, 4'h0, 3'b000);
    tick();
    check("to_rready_entry", bus.axi_rready, 1);
    n = 0;
    while (bus.axi_rready && n < 40) begin
      tick();
      n++;
    end
    check("to_rready_cycles", n, TIMEOUT);
    check("to_rsp_valid", bus.rsp_valid, 1);
    take_rsp("to");

    // rvalid on the same edge the timeout would fire: slave answer wins
    expect_rsp(1'b0, 32'h1234_5678, 2'b01, 1'b0);
    send_cmd(1'b0, 32'h34, 32'h0, 4'h0, 3'b000);
    tick();
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    check("prio_rready_still_high", {bus.axi_rready, bus.rsp_valid}, 2'b10);
    bus.axi_rvalid = 1'b1;
    bus.axi_rdata  = 32'h1234_5678;
    bus.axi_rresp  = 2'b01;
    tick();
    bus.axi_rvalid = 1'b0;
    bus.axi_rdata  = '0;
    bus.axi_rresp  = 2'b00;
    take_rsp("prio");

    // rsp_ready held low: response holds, second command waits
    bus.axi_awready = 1'b1;
    bus.axi_wready  = 1'b1;
    bus.axi_bvalid  = 1'b1;
    bus.axi_bresp   = 2'b00;
    bus.axi_arready = 1'b1;
    bus.axi_rvalid  = 1'b1;
    bus.axi_rdata   = 32'hCAFE_F00D;
    bus.axi_rresp   = 2'b00;
    expect_rsp(1'b1, 32'h0, 2'b00, 1'b0);
    send_cmd(1'b1, 32'h50, 32'h11, 4'hF, 3'b000);
    tick();
    tick();
    check("hold_rsp_valid", bus.rsp_valid, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h58;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_stable", {bus.rsp_valid, bus.rsp_write, bus.rsp_resp, bus.rsp_timeout,
                            bus.cmd_ready, bus.axi_arvalid, bus.rsp_rdata},
            {7'b1100000, 32'h0});
    end
    expect_rsp(1'b0, 32'hCAFE_F00D, 2'b00, 1'b0);
    take_rsp("hold_wr");
    check("hold_next_ready", {bus.cmd_ready, bus.axi_arvalid}, 2'b10);
    tick();
    bus.cmd_valid = 1'b0;
    check("hold_second_accepted", {bus.cmd_ready, bus.axi_arvalid}, 2'b01);
    take_rsp("hold_rd");
    bus.axi_rvalid = 1'b0;
    bus.axi_bvalid = 1'b0;

    // Reset mid-transaction: awvalid high, awready low
    bus.axi_awready = 1'b0;
    bus.axi_wready  = 1'b0;
    bus.axi_arready = 1'b0;
    send_cmd(1'b1, 32'h60, 32'h77, 4'hF, 3'b000);
    tick();
    check("mid_awvalid_high", bus.axi_awvalid, 1);
    #2 aresetn = 1'b0;
    #1;
    check("mid_rst_all_low", {bus.axi_awvalid, bus.axi_wvalid, bus.axi_arvalid, bus.axi_bready,
                              bus.axi_rready, bus.rsp_valid, bus.cmd_ready}, 0);
    check("mid_rst_awaddr", bus.axi_awaddr, 0);
    tick();
    aresetn = 1'b1;
    check("mid_rel_cmd_ready_low", bus.cmd_ready, 0);
    tick();
    check("mid_rel_cmd_ready_high", bus.cmd_ready, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("mid_no_rsp", {bus.rsp_valid, bus.axi_awvalid}, 2'b00);
    end

    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
